seq_pattern_gen: RTL and testbench

//  Serial stimulus generator for the "0101" sequence-detector/counter path.
//  On a start pulse, emits a programmed number of PATTERN frames on num_o, MSB first.

---
 rtl/seq_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial stimulus generator for the "0101" detector/counter path.
// After a start pulse it drives n_pat frames of PATTERN on num_o (MSB first),
// each followed by GAP idle-high bits, then pulses done for one cycle.
// Optional feature macro: SEQ_GEN_ABORT_EN adds an 'abort' input that ends the
// run after the frame (and its gap) that is in flight when abort is seen.
module seq_pattern_gen #(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b0101,
  parameter int unsigned       GAP     = 2,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_pat,
`ifdef SEQ_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             num_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  // Bit counter wide enough to index every bit of one frame.
  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  // Gap counter covers the full 0..15 range of GAP.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [BIT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic [PAT_W-1:0] shreg;
  logic [CNT_W-1:0] sent_inc;
  logic             last_after_send;
  logic             last_after_gap;
  logic             stop_req;
`ifdef SEQ_GEN_ABORT_EN
  logic             abort_flag;
`endif

  // Run-termination decisions: frame count reached, or an abort is pending.
  always_comb begin
    sent_inc        = sent + CNT_W'(1);
    last_after_send = (sent_inc == n_lat);
    last_after_gap  = (sent == n_lat);
`ifdef SEQ_GEN_ABORT_EN
    stop_req        = abort_flag | abort;
`else
    stop_req        = 1'b0;
`endif
  end

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      num_o      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent       <= '0;
      n_lat      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
`ifdef SEQ_GEN_ABORT_EN
      abort_flag <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          num_o <= 1'b1;
          if (start) begin
            sent  <= '0;
            n_lat <= n_pat;
            if (n_pat != '0) begin
              state   <= S_SEND;
              busy    <= 1'b1;
              num_o   <= PATTERN[PAT_W-1];
              shreg   <= PATTERN << 1;
              bit_cnt <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_SEND: begin
`ifdef SEQ_GEN_ABORT_EN
          if (abort) begin
            abort_flag <= 1'b1;
          end
`endif
          if (bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            num_o   <= shreg[PAT_W-1];
            shreg   <= shreg << 1;
          end else begin
            // Edge that ends the last bit of the frame: the frame now counts.
            sent    <= sent_inc;
            bit_cnt <= '0;
            if (GAP != 0) begin
              state   <= S_GAP;
              gap_cnt <= '0;
              num_o   <= 1'b1;
            end else if (last_after_send || stop_req) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              num_o <= 1'b1;
            end else begin
              num_o <= PATTERN[PAT_W-1];
              shreg <= PATTERN << 1;
            end
          end
        end

        S_GAP: begin
`ifdef SEQ_GEN_ABORT_EN
          if (abort) begin
            abort_flag <= 1'b1;
          end
`endif
          num_o <= 1'b1;
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 4'd1;
          end else begin
            gap_cnt <= '0;
            if (last_after_gap || stop_req) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= S_SEND;
              bit_cnt <= '0;
              num_o   <= PATTERN[PAT_W-1];
              shreg   <= PATTERN << 1;
            end
          end
        end

        S_DONE: begin
          // Single done cycle; start seen here is deliberately not accepted.
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          num_o <= 1'b1;
`ifdef SEQ_GEN_ABORT_EN
          abort_flag <= 1'b0;
`endif
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          num_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed bench for seq_pattern_gen with default
// parameters (PATTERN=0101, GAP=2). Build with SEQ_GEN_ABORT_EN to add the abort case.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int GAP   = 2;
  localparam int FRAME = PAT_W + GAP;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_pat;
  logic             num_o;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent;
`ifdef SEQ_GEN_ABORT_EN
  logic             abort;
`endif

  // One frame plus its gap as it must appear on num_o, first bit on the left.
  logic [FRAME-1:0] frameBits = 6'b010111;

  int   errors  = 0;
  int   checks  = 0;
  int   busyCnt = 0;
  int   doneCnt = 0;
  int   detCnt  = 0;
  logic [3:0] window = 4'b1111;

  seq_pattern_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n_pat (n_pat),
`ifdef SEQ_GEN_ABORT_EN
    .abort (abort),
`endif
    .num_o (num_o),
    .busy  (busy),
    .done  (done),
    .sent  (sent)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something upstream stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input int n);
    start = s;
    n_pat = CNT_W'(n);
  endtask

  // Advance to the next falling edge and fold the sampled outputs into the stats.
  task automatic stepCycle();
    @(negedge clk);
    window = {window[2:0], num_o};
    if (window == 4'b0101) detCnt++;
    if (busy) busyCnt++;
    if (done) doneCnt++;
  endtask

  task automatic clearStats();
    busyCnt = 0;
    doneCnt = 0;
    detCnt  = 0;
    window  = 4'b1111;
  endtask

  // One-cycle start pulse; on return the first run cycle has been sampled.
  task automatic launchRun(input int n);
    clearStats();
    applyStimulus(1'b1, n);
    stepCycle();
    applyStimulus(1'b0, 0);
  endtask

  task automatic waitDone(input int maxCycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput("done_seen", 32'(done), 1);
  endtask

  // Compare every cycle of an n-frame run, then the done cycle.
  task automatic checkStream(input int nFrames);
    for (int k = 0; k < nFrames * FRAME; k++) begin
      int pos;
      int expSent;
      pos     = k % FRAME;
      expSent = k / FRAME + ((pos >= PAT_W) ? 1 : 0);
      checkOutput("stream_bit", 32'(num_o), 32'(frameBits[FRAME-1-pos]));
      checkOutput("stream_busy", 32'(busy), 1);
      checkOutput("stream_sent", 32'(sent), 32'(expSent));
      stepCycle();
    end
    checkOutput("end_done", 32'(done), 1);
    checkOutput("end_busy", 32'(busy), 0);
    checkOutput("end_num", 32'(num_o), 1);
    checkOutput("end_sent", 32'(sent), 32'(nFrames));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 3);
`ifdef SEQ_GEN_ABORT_EN
    abort = 1'b0;
`endif

    // Reset values, with start held high while in reset.
    repeat (3) stepCycle();
    checkOutput("rst_num", 32'(num_o), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_sent", 32'(sent), 0);
    applyStimulus(1'b0, 0);
    rst_n = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("idle_busy", 32'(busy), 0);

    // Three frames: 0101 11 x3, busy for 18 cycles, done in cycle 19.
    launchRun(3);
    checkStream(3);
    checkOutput("run3_busy_cycles", 32'(busyCnt), 18);
    checkOutput("run3_detected", 32'(detCnt), 3);
    stepCycle();
    checkOutput("run3_done_drop", 32'(done), 0);
    checkOutput("run3_sent_hold", 32'(sent), 3);

    // Zero frames: done immediately, nothing driven, sent cleared.
    launchRun(0);
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_busy", 32'(busy), 0);
    checkOutput("zero_num", 32'(num_o), 1);
    checkOutput("zero_sent", 32'(sent), 0);
    stepCycle();
    checkOutput("zero_done_drop", 32'(done), 0);
    checkOutput("zero_busy_cycles", 32'(busyCnt), 0);

    // Start re-pulsed mid-run is ignored; start in DONE is ignored too.
    launchRun(2);
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 7);
    stepCycle();
    applyStimulus(1'b0, 0);
    waitDone(40);
    checkOutput("repulse_busy_cycles", 32'(busyCnt), 12);
    checkOutput("repulse_sent", 32'(sent), 2);
    checkOutput("repulse_detected", 32'(detCnt), 2);
    checkOutput("repulse_done_pulses", 32'(doneCnt), 1);
    applyStimulus(1'b1, 1);
    stepCycle();
    checkOutput("done_start_ignored", 32'(busy), 0);
    checkOutput("done_single_pulse", 32'(done), 0);
    stepCycle();
    applyStimulus(1'b0, 0);
    checkOutput("reaccept_busy", 32'(busy), 1);
    checkOutput("reaccept_num", 32'(num_o), 0);
    checkOutput("reaccept_sent_clear", 32'(sent), 0);
    waitDone(20);
    checkOutput("reaccept_sent", 32'(sent), 1);
    stepCycle();

    // Reset during bit 2 of frame 2, then a clean single-frame run.
    launchRun(5);
    repeat (7) stepCycle();
    checkOutput("pre_rst_sent", 32'(sent), 1);
    checkOutput("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_num", 32'(num_o), 1);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_done", 32'(done), 0);
    checkOutput("mid_rst_sent", 32'(sent), 0);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post_rst_busy", 32'(busy), 0);
    launchRun(1);
    checkStream(1);
    checkOutput("post_rst_detected", 32'(detCnt), 1);
    stepCycle();

`ifdef SEQ_GEN_ABORT_EN
    // Abort during frame 4 of 10: frame 4 and its gap finish, then done.
    launchRun(10);
    repeat (19) stepCycle();
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    waitDone(80);
    checkOutput("abort_busy_cycles", 32'(busyCnt), 24);
    checkOutput("abort_sent", 32'(sent), 4);
    checkOutput("abort_detected", 32'(detCnt), 4);
    stepCycle();
    checkOutput("abort_done_drop", 32'(done), 0);
    launchRun(1);
    checkStream(1);
    stepCycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
